screen_line_fetch: RTL

SCREEN_LINE_FETCH -- requirements
Module: screen_line_fetch

---
 rtl/screen_line_fetch.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/screen_line_fetch.sv
// Screen line fetch: once per video line, reads the memory words for the
// next displayed row into a small line buffer and serves one memory bit
// per binary-area pixel from that buffer.
module screen_line_fetch #(
    parameter int DATA_WIDTH              = 16,
    parameter int BITS_PER_MEMORY_PIXEL_X = 4,
    parameter int BITS_PER_MEMORY_PIXEL_Y = 5,
    parameter int HEX_START_X             = 512,
    parameter int H_FETCH_START           = 640,
    parameter int V_TOTAL                 = 525,
    parameter int RAM_LATENCY             = 1
) (
    input  logic                  CLK_50,
    input  logic                  reset,
    input  logic [9:0]            pixel_x,
    input  logic [9:0]            pixel_y,
    output logic [DATA_WIDTH-1:0] addr_screen,
    input  logic [DATA_WIDTH-1:0] rdata_screen,
    output logic                  pixel_bit,
    output logic                  pixel_valid,
    output logic                  fetch_busy,
    output logic                  overrun
);

    localparam int WORD_SHIFT     = $clog2(DATA_WIDTH) + BITS_PER_MEMORY_PIXEL_X;
    localparam int WORDS_PER_LINE = 512 >> WORD_SHIFT;
    localparam int WIDX_W         = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int BPOS_W         = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    // Line after y, wrapping at the bottom of the frame.
    function automatic logic [10:0] next_line(input logic [9:0] y);
        logic [10:0] y1;
        y1 = {1'b0, y} + 11'd1;
        return (y1 == 11'(V_TOTAL)) ? 11'd0 : y1;
    endfunction

    logic [1:0]            state;
    logic [WIDX_W-1:0]     issue_cnt;
    logic [10:0]           row_p0;
    logic [9:0]            px_p0;
    logic                  line_ok;
    logic [RAM_LATENCY-1:0] rd_vld_p;
    logic [WIDX_W-1:0]     rd_idx_p [RAM_LATENCY];
    logic [DATA_WIDTH-1:0] line_buf [WORDS_PER_LINE];

    logic                  trigger;
    logic [10:0]           trig_row;
    logic                  last_issue;
    logic                  early_pending;
    logic [WIDX_W-1:0]     w_sel;
    logic [BPOS_W-1:0]     b_sel;

    assign trigger    = (pixel_x == 10'(H_FETCH_START)) && (px_p0 != 10'(H_FETCH_START));
    assign trig_row   = next_line(pixel_y) >> BITS_PER_MEMORY_PIXEL_Y;
    assign last_issue = (issue_cnt == WIDX_W'(WORDS_PER_LINE - 1));
    assign fetch_busy = (state != IDLE);
    assign w_sel      = WIDX_W'(pixel_x >> WORD_SHIFT);
    assign b_sel      = BPOS_W'(DATA_WIDTH - 1) - BPOS_W'(pixel_x >> BITS_PER_MEMORY_PIXEL_X);

    // Reads still in flight other than the one returning this cycle.
    always_comb begin
        early_pending = 1'b0;
        for (int k = 0; k < RAM_LATENCY - 1; k++) begin
            early_pending = early_pending | rd_vld_p[k];
        end
    end

    // Fetch FSM, address generation, return tracking and status flags.
    always_ff @(posedge CLK_50 or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            issue_cnt   <= '0;
            row_p0      <= '0;
            px_p0       <= '0;
            addr_screen <= '0;
            line_ok     <= 1'b0;
            overrun     <= 1'b0;
            rd_vld_p    <= '0;
            for (int k = 0; k < RAM_LATENCY; k++) begin
                rd_idx_p[k] <= '0;
            end
        end else begin
            px_p0 <= pixel_x;

            // stage boundary: issued address -> RAM return alignment
            rd_vld_p[0] <= (state == ISSUE);
            rd_idx_p[0] <= issue_cnt;
            for (int k = 1; k < RAM_LATENCY; k++) begin
                rd_vld_p[k] <= rd_vld_p[k-1];
                rd_idx_p[k] <= rd_idx_p[k-1];
            end

            if (rd_vld_p[RAM_LATENCY-1] &&
                rd_idx_p[RAM_LATENCY-1] == WIDX_W'(WORDS_PER_LINE - 1)) begin
                line_ok <= 1'b1;
            end

            if (trigger && fetch_busy) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (trigger) begin
                        state       <= ISSUE;
                        issue_cnt   <= '0;
                        row_p0      <= trig_row;
                        addr_screen <= DATA_WIDTH'(32'(trig_row) * 32'(WORDS_PER_LINE));
                        line_ok     <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (last_issue) begin
                        state <= DRAIN;
                    end else begin
                        issue_cnt   <= issue_cnt + 1'b1;
                        addr_screen <= DATA_WIDTH'(32'(row_p0) * 32'(WORDS_PER_LINE)
                                                   + 32'(issue_cnt) + 32'd1);
                    end
                end
                DRAIN: begin
                    if (!early_pending) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line buffer write from the aligned RAM return.
    always_ff @(posedge CLK_50) begin
        if (rd_vld_p[RAM_LATENCY-1]) begin
            line_buf[rd_idx_p[RAM_LATENCY-1]] <= rdata_screen;
        end
    end

    // Registered pixel lookup, MSB of each word shown leftmost.
    always_ff @(posedge CLK_50 or posedge reset) begin
        if (reset) begin
            pixel_bit   <= 1'b0;
            pixel_valid <= 1'b0;
        end else begin
            pixel_bit   <= line_buf[w_sel][b_sel];
            pixel_valid <= (pixel_x < 10'(HEX_START_X)) && (pixel_y < 10'd480) && line_ok;
        end
    end

endmodule
